// File: rtl/spi_fsm_pkg.sv
// Shared definitions for the SPI memory transaction controller:
// state encoding, default byte width, R/W polarity and the control-output bundle.
package spi_fsm_pkg;

    localparam int unsigned BITS_DEFAULT = 8;
    localparam int unsigned CNT_W        = 4;
    localparam logic        RW_READ      = 1'b1;

    typedef enum logic [3:0] {
        IDLE        = 4'd0,
        GET_ADDR    = 4'd1,
        GOT_ADDR    = 4'd2,
        READ_WAIT   = 4'd3,
        READ_LOAD   = 4'd4,
        READ_SHIFT  = 4'd5,
        WRITE_RECV  = 4'd6,
        WRITE_STORE = 4'd7,
        DONE        = 4'd8
    } state_t;

    typedef struct packed {
        logic sr_load;
        logic addr_we;
        logic dm_we;
        logic miso_en;
    } ctrl_t;

    // Moore output decode: each strobe belongs to exactly one state.
    function automatic ctrl_t decode_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            GOT_ADDR:    c.addr_we = 1'b1;
            READ_LOAD:   c.sr_load = 1'b1;
            READ_SHIFT:  c.miso_en = 1'b1;
            WRITE_STORE: c.dm_we   = 1'b1;
            default:     c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/spi_bitcounter.sv
// Saturating bit counter; clear wins over inc, and the count holds at MAX.
module spi_bitcounter
    import spi_fsm_pkg::*;
#(
    parameter int unsigned MAX = BITS_DEFAULT,
    parameter int unsigned W   = CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != W'(MAX))) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/spi_fsm.sv
// SPI memory transaction controller: address byte, R/W bit, then one data byte
// either shifted out (read) or stored (write). Outputs are registered Moore strobes.
module spi_fsm
    import spi_fsm_pkg::*;
#(
    parameter int unsigned BITS = BITS_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic cs,
    input  logic sclkPosEdge,
    input  logic sclkNegEdge,
    input  logic rwBit,
    output logic srLoad,
    output logic addrWe,
    output logic dmWe,
    output logic misoEn
);

    localparam logic [CNT_W-1:0] TERM    = CNT_W'(BITS);
    localparam logic [CNT_W-1:0] TERM_M1 = CNT_W'(BITS - 1);

    state_t           state, state_next;
    ctrl_t            ctrl_q;
    logic [CNT_W-1:0] count;
    logic             cnt_clear, cnt_inc;
    logic             cnt_done;

    spi_bitcounter #(.MAX(BITS), .W(CNT_W)) u_bitcounter (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clear),
        .inc   (cnt_inc),
        .count (count)
    );

    // Leave a counting state on the same edge that completes the last bit.
    assign cnt_done = (count == TERM) || (cnt_inc && (count == TERM_M1));

    // Next state and counter control; chip-select release aborts from anywhere.
    always_comb begin
        state_next = state;
        cnt_clear  = 1'b0;
        cnt_inc    = 1'b0;
        if ((state != IDLE) && cs) begin
            state_next = IDLE;
            cnt_clear  = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (!cs) begin
                        state_next = GET_ADDR;
                        cnt_inc    = sclkPosEdge;
                        cnt_clear  = !sclkPosEdge;
                    end else begin
                        cnt_clear  = 1'b1;
                    end
                end
                GET_ADDR: begin
                    cnt_inc = sclkPosEdge;
                    if (cnt_done) state_next = GOT_ADDR;
                end
                GOT_ADDR: begin
                    cnt_clear  = 1'b1;
                    state_next = (rwBit == RW_READ) ? READ_WAIT : WRITE_RECV;
                end
                READ_WAIT: begin
                    cnt_clear  = 1'b1;
                    state_next = READ_LOAD;
                end
                READ_LOAD: begin
                    cnt_clear  = 1'b1;
                    state_next = READ_SHIFT;
                end
                READ_SHIFT: begin
                    cnt_inc = sclkNegEdge;
                    if (cnt_done) state_next = DONE;
                end
                WRITE_RECV: begin
                    cnt_inc = sclkPosEdge;
                    if (cnt_done) state_next = WRITE_STORE;
                end
                WRITE_STORE: begin
                    cnt_clear  = 1'b1;
                    state_next = DONE;
                end
                DONE: begin
                    cnt_clear  = 1'b1;
                end
                default: begin
                    cnt_clear  = 1'b1;
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they align with the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            ctrl_q <= '0;
        end else begin
            state  <= state_next;
            ctrl_q <= decode_ctrl(state_next);
        end
    end

    assign srLoad = ctrl_q.sr_load;
    assign addrWe = ctrl_q.addr_we;
    assign dmWe   = ctrl_q.dm_we;
    assign misoEn = ctrl_q.miso_en;

endmodule

// File: tb/tb_spi_fsm.sv
// Directed bench for spi_fsm: write, read, abort, coincident edge, stray edges, async reset.
module tb_spi_fsm;

    logic clk = 1'b0;
    logic reset, cs, sclkPosEdge, sclkNegEdge, rwBit;
    logic srLoad, addrWe, dmWe, misoEn;
    logic [3:0] outs;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [3:0] O_NONE = 4'b0000;
    localparam logic [3:0] O_LOAD = 4'b1000;
    localparam logic [3:0] O_ADDR = 4'b0100;
    localparam logic [3:0] O_DMWE = 4'b0010;
    localparam logic [3:0] O_MISO = 4'b0001;

    spi_fsm #(.BITS(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .cs          (cs),
        .sclkPosEdge (sclkPosEdge),
        .sclkNegEdge (sclkNegEdge),
        .rwBit       (rwBit),
        .srLoad      (srLoad),
        .addrWe      (addrWe),
        .dmWe        (dmWe),
        .misoEn      (misoEn)
    );

    always #5 clk = ~clk;

    assign outs = {srLoad, addrWe, dmWe, misoEn};

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got {srLoad,addrWe,dmWe,misoEn}=%b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pos_strobe();
        sclkPosEdge = 1'b1;
        tick();
        sclkPosEdge = 1'b0;
    endtask

    task automatic neg_strobe();
        sclkNegEdge = 1'b1;
        tick();
        sclkNegEdge = 1'b0;
    endtask

    // n address strobes with gaps; addrWe must appear right after the last one.
    task automatic addr_phase(input logic rw, input int n, input string tag);
        for (int i = 1; i <= n; i++) begin
            if (i == n) rwBit = rw;
            pos_strobe();
            if (i < n) begin
                check(tag, outs, O_NONE);
                tick();
            end else begin
                check(tag, outs, O_ADDR);
            end
        end
    endtask

    // Eight write-data strobes; dmWe must appear right after the 8th.
    task automatic write_data(input string tag);
        for (int i = 1; i <= 8; i++) begin
            pos_strobe();
            check(tag, outs, (i == 8) ? O_DMWE : O_NONE);
            if (i < 8) tick();
        end
    endtask

    // From IDLE: drop cs, send the address byte, and walk the read path into READ_SHIFT.
    task automatic start_read(input string tag);
        cs = 1'b0;
        tick();
        addr_phase(1'b1, 8, tag);
        tick();
        check({tag, "_wait"}, outs, O_NONE);
        tick();
        check({tag, "_srload"}, outs, O_LOAD);
        tick();
        check({tag, "_misoen"}, outs, O_MISO);
    endtask

    initial begin
        reset = 1'b1; cs = 1'b1; sclkPosEdge = 1'b0; sclkNegEdge = 1'b0; rwBit = 1'b0;
        tick();
        check("reset_outs", outs, O_NONE);
        tick();
        reset = 1'b0;
        tick();
        check("idle_after_reset", outs, O_NONE);

        // Write: address 0x15 + W, data 0xA3 (data content is opaque to the controller).
        cs = 1'b0;
        tick();
        check("w_get_addr", outs, O_NONE);
        addr_phase(1'b0, 8, "w_addr");
        tick();
        check("w_addrwe_1cyc", outs, O_NONE);
        write_data("w_data");
        tick();
        check("w_dmwe_1cyc", outs, O_NONE);
        tick();
        check("w_done", outs, O_NONE);
        cs = 1'b1;
        tick();
        check("w_idle", outs, O_NONE);

        // Read: address 0x15 + R; a pos strobe during shift must not be counted.
        start_read("r");
        for (int i = 1; i <= 8; i++) begin
            if (i == 4) begin
                pos_strobe();
                check("r_stray_pos", outs, O_MISO);
            end
            neg_strobe();
            check("r_shift", outs, (i == 8) ? O_NONE : O_MISO);
            if (i < 8) tick();
        end
        // DONE must hold while cs stays low, even across a full byte of edges.
        for (int i = 0; i < 8; i++) begin
            pos_strobe();
            check("r_done_hold", outs, O_NONE);
            tick();
        end
        cs = 1'b1;
        tick();
        check("r_idle", outs, O_NONE);

        // Abort a write after the 5th data bit, then a full write must still work.
        cs = 1'b0;
        tick();
        addr_phase(1'b0, 8, "a_addr");
        tick();
        for (int i = 0; i < 5; i++) begin
            pos_strobe();
            check("a_data", outs, O_NONE);
            tick();
        end
        cs = 1'b1;
        tick();
        check("a_abort", outs, O_NONE);
        for (int i = 0; i < 4; i++) begin
            pos_strobe();
            check("a_no_dmwe", outs, O_NONE);
        end
        cs = 1'b0;
        tick();
        addr_phase(1'b0, 8, "a2_addr");
        tick();
        write_data("a2_data");
        tick();
        check("a2_dmwe_1cyc", outs, O_NONE);
        cs = 1'b1;
        tick();

        // cs fall coincident with a pos strobe counts as bit 1.
        cs = 1'b0;
        sclkPosEdge = 1'b1;
        tick();
        sclkPosEdge = 1'b0;
        check("c_first", outs, O_NONE);
        tick();
        addr_phase(1'b0, 7, "c_addr");
        tick();
        cs = 1'b1;
        tick();
        check("c_abort", outs, O_NONE);

        // Stray strobes in DONE after a write, then release.
        cs = 1'b0;
        tick();
        addr_phase(1'b0, 8, "s_addr");
        tick();
        write_data("s_data");
        tick();
        for (int i = 0; i < 3; i++) begin
            pos_strobe();
            check("s_stray", outs, O_NONE);
        end
        cs = 1'b1;
        tick();
        check("s_idle", outs, O_NONE);

        // Asynchronous reset in READ_SHIFT drops misoEn between clock edges.
        start_read("x");
        neg_strobe();
        check("x_shift", outs, O_MISO);
        #2;
        reset = 1'b1;
        #1;
        check("x_rst_async", outs, O_NONE);
        cs = 1'b1;
        tick();
        check("x_rst_hold", outs, O_NONE);
        tick();
        reset = 1'b0;
        tick();
        check("x_idle", outs, O_NONE);
        cs = 1'b0;
        tick();
        addr_phase(1'b1, 8, "x_addr");
        cs = 1'b1;
        tick();
        check("x_end", outs, O_NONE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
